// File: rtl/fp_addsub_if.sv
// rtl/fp_addsub_if.sv - stb/ack handshake bundle for the floating-point adder/subtractor
// Ports (W = word width):
//   input_a / input_a_stb / input_a_ack        operand A and its handshake
//   input_b / input_op / input_b_stb / input_b_ack   operand B, add/sub select and handshake
//   output_z / output_z_stb / output_z_ack     result and its handshake
// master = operand producer / result consumer, slave = the adder.
interface fp_addsub_if #(
  parameter int W = 32
);
  logic [W-1:0] input_a;
  logic         input_a_stb;
  logic         input_a_ack;
  logic [W-1:0] input_b;
  logic         input_op;
  logic         input_b_stb;
  logic         input_b_ack;
  logic [W-1:0] output_z;
  logic         output_z_stb;
  logic         output_z_ack;

  modport master (
    output input_a, input_a_stb, input_b, input_op, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_op, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fp_addsub.sv
// rtl/fp_addsub.sv - parametrised floating-point adder/subtractor, round-to-nearest-even
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  fp_addsub_if.slave: A, B(+op) operands in, Z result out, each with stb/ack
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic       clk,
  input  logic       rst,
  fp_addsub_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;               // mantissa with hidden bit
  localparam int M1   = M + 1;
  localparam int XW   = M + 3;                   // plus guard, round, sticky
  localparam int EW   = EXP_W + 2;               // signed unbiased exponent
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [3:0] S_GET_A   = 4'd0;
  localparam logic [3:0] S_GET_B   = 4'd1;
  localparam logic [3:0] S_UNPACK  = 4'd2;
  localparam logic [3:0] S_SPECIAL = 4'd3;
  localparam logic [3:0] S_ALIGN   = 4'd4;
  localparam logic [3:0] S_ADD     = 4'd5;
  localparam logic [3:0] S_NORM    = 4'd6;
  localparam logic [3:0] S_ROUND   = 4'd7;
  localparam logic [3:0] S_PACK    = 4'd8;
  localparam logic [3:0] S_PUT_Z   = 4'd9;

  logic [3:0]          r_state;
  logic                r_a_ack, r_b_ack, r_z_stb;
  logic [W-1:0]        r_a, r_b, r_z, r_spec_z;
  logic                r_op, r_sa, r_sb, r_special, r_sign, r_sub, r_zero;
  logic signed [EW-1:0] r_ea, r_eb, r_e;
  logic [M-1:0]        r_ma, r_mb, r_rm;
  logic [XW-1:0]       r_mx, r_my, r_m;
  logic [XW:0]         r_sum;

  logic [EXP_W-1:0]    w_exp_a, w_exp_b;
  logic [MAN_W-1:0]    w_man_a, w_man_b;
  logic                w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic                w_is_special;
  logic [W-1:0]        w_spec_z, w_pack;
  logic                w_swap, w_sticky, w_found, w_rup;
  logic signed [EW-1:0] w_el, w_es, w_diff, w_bexp;
  logic [M-1:0]        w_ml, w_ms;
  logic [XW-1:0]       w_ext, w_shifted, w_my;
  logic [M1-1:0]       w_rnd;
  int                  w_lz, w_room, w_sh;

  assign w_exp_a  = r_a[W-2:MAN_W];
  assign w_exp_b  = r_b[W-2:MAN_W];
  assign w_man_a  = r_a[MAN_W-1:0];
  assign w_man_b  = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_exp_a) && (|w_man_a);
  assign w_b_nan  = (&w_exp_b) && (|w_man_b);
  assign w_a_inf  = (&w_exp_a) && !(|w_man_a);
  assign w_b_inf  = (&w_exp_b) && !(|w_man_b);
  assign w_a_zero = ~|r_a[W-2:0];
  assign w_b_zero = ~|r_b[W-2:0];

  // r_sb already carries the op inversion, so inf-inf shows up as opposite signs.
  always_comb begin
    w_is_special = 1'b1;
    w_spec_z     = QNAN;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_sa != r_sb))) w_spec_z = QNAN;
    else if (w_a_inf)                w_spec_z = {r_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_b_inf)                w_spec_z = {r_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_a_zero && w_b_zero)   w_spec_z = {r_sa & r_sb, {(W-1){1'b0}}};
    else                             w_is_special = 1'b0;
  end

  // Raw exp/man fields order the same way as (exponent, mantissa) pairs,
  // subnormals included, so they pick the reference operand directly.
  always_comb begin
    w_swap = r_b[W-2:0] > r_a[W-2:0];
    w_el   = w_swap ? r_eb : r_ea;
    w_es   = w_swap ? r_ea : r_eb;
    w_ml   = w_swap ? r_mb : r_ma;
    w_ms   = w_swap ? r_ma : r_mb;
    w_diff = w_el - w_es;
    w_ext  = {w_ms, 3'b000};
    if (int'(w_diff) >= MAN_W + 3) begin
      w_shifted = '0;
      w_sticky  = |w_ms;
    end else begin
      w_shifted = w_ext >> w_diff;
      w_sticky  = |(w_ext & ~({XW{1'b1}} << w_diff));
    end
    w_my = w_shifted | {{(XW-1){1'b0}}, w_sticky};
  end

  // Left-normalise no further than the minimum exponent; what remains is subnormal.
  always_comb begin
    w_lz    = 0;
    w_found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (r_sum[i]) w_found = 1'b1;
        else          w_lz    = w_lz + 1;
      end
    end
    w_room = int'(r_e) - EMIN;
    w_sh   = (w_lz < w_room) ? w_lz : w_room;
  end

  assign w_rup = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
  assign w_rnd = {1'b0, r_m[XW-1:3]} + M1'(w_rup);

  always_comb begin
    w_bexp = r_e + EW'(BIAS);
    if (r_special)           w_pack = r_spec_z;
    else if (r_zero)         w_pack = '0;
    else if (!r_rm[M-1])     w_pack = {r_sign, {EXP_W{1'b0}}, r_rm[MAN_W-1:0]};
    else if (int'(w_bexp) >= EMAX) w_pack = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                     w_pack = {r_sign, w_bexp[EXP_W-1:0], r_rm[MAN_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GET_A;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_z_stb <= 1'b0;
      r_z     <= '0;
    end else begin
      case (r_state)
        S_GET_A: begin
          if (r_a_ack && bus.input_a_stb) begin
            r_a     <= bus.input_a;
            r_a_ack <= 1'b0;
            r_state <= S_GET_B;
          end else begin
            r_a_ack <= 1'b1;
          end
        end
        S_GET_B: begin
          if (r_b_ack && bus.input_b_stb) begin
            r_b     <= bus.input_b;
            r_op    <= bus.input_op;
            r_b_ack <= 1'b0;
            r_state <= S_UNPACK;
          end else begin
            r_b_ack <= 1'b1;
          end
        end
        S_UNPACK: begin
          r_sa    <= r_a[W-1];
          r_sb    <= r_b[W-1] ^ r_op;
          r_ea    <= (w_exp_a == '0) ? EW'(EMIN) : EW'(int'(w_exp_a) - BIAS);
          r_eb    <= (w_exp_b == '0) ? EW'(EMIN) : EW'(int'(w_exp_b) - BIAS);
          r_ma    <= {|w_exp_a, w_man_a};
          r_mb    <= {|w_exp_b, w_man_b};
          r_state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          // Special results bypass the arithmetic stages; PACK forwards them,
          // giving the fixed short latency.
          r_special <= w_is_special;
          r_spec_z  <= w_spec_z;
          r_state   <= w_is_special ? S_PACK : S_ALIGN;
        end
        S_ALIGN: begin
          r_mx    <= {w_ml, 3'b000};
          r_my    <= w_my;
          r_e     <= w_el;
          r_sign  <= w_swap ? r_sb : r_sa;
          r_sub   <= r_sa != r_sb;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum[XW]) begin
            r_m <= {r_sum[XW:2], r_sum[1] | r_sum[0]};
            r_e <= r_e + EW'(1);
          end else begin
            r_m <= r_sum[XW-1:0] << w_sh;
            r_e <= r_e - EW'(w_sh);
          end
          r_zero  <= ~|r_sum;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (w_rnd[M]) begin
            r_rm <= w_rnd[M:1];
            r_e  <= r_e + EW'(1);
          end else begin
            r_rm <= w_rnd[M-1:0];
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          r_z     <= w_pack;
          r_z_stb <= 1'b1;
          r_state <= S_PUT_Z;
        end
        S_PUT_Z: begin
          if (bus.output_z_ack) begin
            r_z_stb <= 1'b0;
            r_state <= S_GET_A;
          end
        end
        default: r_state <= S_GET_A;
      endcase
    end
  end

  assign bus.input_a_ack  = r_a_ack;
  assign bus.input_b_ack  = r_b_ack;
  assign bus.output_z     = r_z;
  assign bus.output_z_stb = r_z_stb;
endmodule
